sdram_device_model: RTL and testbench

Synthesizable single-chip SDR SDRAM responder: the device end of the same SDRAM pin interface our controller drives. It decodes CS/RAS/CAS/WE commands, tracks mode register and per-bank open rows, stores write data in an on-chip array, and returns read bursts at the programmed CAS latency. It also checks command legality and cycle timing and reports the first violation. It sits in FPGA loopback tests and simulation benches in place of the external chip.

---
 rtl/sdram_pkg.sv | 53 +++++
 rtl/sdram_model_bank.sv | 53 +++++
 rtl/sdram_device_model.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_device_model.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDR SDRAM device model: command/error encodings and
// mode-register field decoders.
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_LMR   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WRITE = 4'b0100,
        CMD_READ  = 4'b0101,
        CMD_BST   = 4'b0110,
        CMD_NOP   = 4'b0111,
        CMD_DESEL = 4'b1000
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_CLOSED   = 3'd1,
        ERR_ACT_OPEN = 3'd2,
        ERR_REF_OPEN = 3'd3,
        ERR_TRCD     = 3'd4,
        ERR_TRP      = 3'd5,
        ERR_TIMING   = 3'd6,
        ERR_LMR      = 3'd7
    } err_e;

    function automatic cmd_e cmd_decode(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        return cs_n ? CMD_DESEL : cmd_e'({1'b0, ras_n, cas_n, we_n});
    endfunction

    // Burst length in beats; 0 marks an illegal field.
    function automatic logic [3:0] bl_decode(input logic [2:0] f);
        case (f)
            3'b000:  return 4'd1;
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // CAS latency in cycles; 0 marks an illegal field.
    function automatic logic [1:0] cl_decode(input logic [2:0] f);
        case (f)
            3'd2:    return 2'd2;
            3'd3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_model_bank.sv
// One SDRAM bank: open/row state, tRCD/tRP down-counters and pending
// auto-precharge that closes the bank when its burst finishes.
module sdram_model_bank #(
    parameter int RAW      = 12,
    parameter int tRCD_CYC = 2,
    parameter int tRP_CYC  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           act,
    input  logic           pre,
    input  logic           rw,
    input  logic           ap,
    input  logic           burst_end,
    input  logic [RAW-1:0] row_in,
    output logic           is_open,
    output logic [RAW-1:0] row,
    output logic           trcd_ok,
    output logic           trp_ok
);
    logic [3:0] trcd_cnt, trp_cnt;
    logic       ap_pending, ap_close;

    // A BL=1 access ends on its own command edge, so honour its ap bit directly.
    assign ap_close = burst_end && (rw ? ap : ap_pending);
    assign trcd_ok  = (trcd_cnt == 4'd0);
    assign trp_ok   = (trp_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            is_open    <= 1'b0;
            row        <= '0;
            trcd_cnt   <= 4'd0;
            trp_cnt    <= 4'd0;
            ap_pending <= 1'b0;
        end else begin
            if (trcd_cnt != 4'd0) trcd_cnt <= trcd_cnt - 4'd1;
            if (trp_cnt != 4'd0)  trp_cnt  <= trp_cnt - 4'd1;
            if (rw) ap_pending <= ap;
            if (act) begin
                is_open  <= 1'b1;
                row      <= row_in;
                trcd_cnt <= 4'(tRCD_CYC - 1);
            end
            if (pre || ap_close) begin
                is_open    <= 1'b0;
                ap_pending <= 1'b0;
                trp_cnt    <= 4'(tRP_CYC - 1);
            end
        end
    end

endmodule

// File: rtl/sdram_device_model.sv
// SDR SDRAM device responder: command decode and legality checks, mode
// register, burst engine, on-chip array and CAS-latency read pipeline.
module sdram_device_model
    import sdram_pkg::*;
#(
    parameter int DW       = 16,
    parameter int RAW      = 12,
    parameter int CAW      = 8,
    parameter int MEM_AW   = 12,
    parameter int tRCD_CYC = 2,
    parameter int tRP_CYC  = 2,
    parameter int tRFC_CYC = 4,
    parameter int tMRD_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sdram_cke,
    input  logic            sdram_cs_n,
    input  logic            sdram_ras_n,
    input  logic            sdram_cas_n,
    input  logic            sdram_we_n,
    input  logic [RAW-1:0]  sdram_addr,
    input  logic [1:0]      sdram_ba,
    input  logic [DW/8-1:0] sdram_dqm,
    inout  wire  [DW-1:0]   sdram_dq,
    output logic            mode_valid,
    output logic            protocol_error,
    output logic [2:0]      err_code
);
    localparam int NB = DW / 8;

    cmd_e cmd;
    err_e err;
    logic do_act, do_rw, do_pre, do_ref, do_lmr, do_bst;
    logic [3:0] bank_open, trcd_ok, trp_ok, act_v, pre_v, rw_v, end_v;
    logic [3:0][RAW-1:0] bank_row;

    logic [3:0] mode_bl;
    logic [1:0] mode_cl, tap;
    logic [3:0] gtimer;

    logic           burst_act, burst_wr;
    logic [1:0]     burst_ba;
    logic [RAW-1:0] burst_row;
    logic [CAW-1:0] burst_col, col_mask;
    logic [3:0]     burst_len, burst_k;

    logic           beat_vld, beat_wr, beat_last;
    logic [1:0]     beat_ba;
    logic [RAW-1:0] beat_row;
    logic [CAW-1:0] beat_col;
    logic [3:0]     beat_k;
    logic [MEM_AW-1:0] idx;

    logic [DW-1:0]         mem [2**MEM_AW];
    logic [2:0]            vld_pipe;
    logic [2:0][DW-1:0]    rd_pipe;
    logic [NB-1:0]         dqm_d1, dqm_d2;

    assign cmd = sdram_cke ? cmd_decode(sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n)
                           : CMD_NOP;

    always_comb begin
        err = ERR_NONE;
        case (cmd)
            CMD_READ, CMD_WRITE:
                if (!mode_valid || gtimer != 4'd0) err = ERR_TIMING;
                else if (!bank_open[sdram_ba])     err = ERR_CLOSED;
                else if (!trcd_ok[sdram_ba])       err = ERR_TRCD;
            CMD_ACT:
                if (!mode_valid || gtimer != 4'd0) err = ERR_TIMING;
                else if (bank_open[sdram_ba])      err = ERR_ACT_OPEN;
                else if (!trp_ok[sdram_ba])        err = ERR_TRP;
            CMD_REF:
                if (gtimer != 4'd0)  err = ERR_TIMING;
                else if (|bank_open) err = ERR_REF_OPEN;
            CMD_LMR:
                if (gtimer != 4'd0) err = ERR_TIMING;
                else if (bl_decode(sdram_addr[2:0]) == 4'd0 || cl_decode(sdram_addr[6:4]) == 2'd0)
                    err = ERR_LMR;
            CMD_PRE, CMD_BST:
                if (gtimer != 4'd0) err = ERR_TIMING;
            default: ;
        endcase
    end

    // Illegal commands are dropped entirely.
    assign do_rw  = (err == ERR_NONE) && (cmd == CMD_READ || cmd == CMD_WRITE);
    assign do_act = (err == ERR_NONE) && (cmd == CMD_ACT);
    assign do_pre = (err == ERR_NONE) && (cmd == CMD_PRE);
    assign do_ref = (err == ERR_NONE) && (cmd == CMD_REF);
    assign do_lmr = (err == ERR_NONE) && (cmd == CMD_LMR);
    assign do_bst = (err == ERR_NONE) && (cmd == CMD_BST);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        assign act_v[b] = do_act && (sdram_ba == 2'(b));
        assign pre_v[b] = do_pre && (sdram_addr[10] || sdram_ba == 2'(b));
        assign rw_v[b]  = do_rw && (sdram_ba == 2'(b));
        assign end_v[b] = beat_vld && beat_last && (beat_ba == 2'(b));
        sdram_model_bank #(.RAW(RAW), .tRCD_CYC(tRCD_CYC), .tRP_CYC(tRP_CYC)) u_bank (
            .clk(clk), .rst(rst), .act(act_v[b]), .pre(pre_v[b]), .rw(rw_v[b]),
            .ap(sdram_addr[10]), .burst_end(end_v[b]), .row_in(sdram_addr),
            .is_open(bank_open[b]), .row(bank_row[b]), .trcd_ok(trcd_ok[b]), .trp_ok(trp_ok[b])
        );
    end

    // Column access for this edge: beat 0 of a new command or the next beat of
    // the running burst. The burst advances in command time for reads too; the
    // pipeline below adds the CAS delay. Low column bits wrap modulo BL.
    assign col_mask = CAW'(burst_len - 4'd1);
    always_comb begin
        beat_vld  = 1'b0;
        beat_wr   = 1'b0;
        beat_ba   = burst_ba;
        beat_row  = burst_row;
        beat_col  = (burst_col & ~col_mask) | ((burst_col + CAW'(burst_k)) & col_mask);
        beat_k    = burst_k;
        beat_last = (burst_k == burst_len - 4'd1);
        if (do_rw) begin
            beat_vld  = 1'b1;
            beat_wr   = (cmd == CMD_WRITE);
            beat_ba   = sdram_ba;
            beat_row  = bank_row[sdram_ba];
            beat_col  = sdram_addr[CAW-1:0];
            beat_k    = 4'd0;
            beat_last = (mode_bl == 4'd1);
        end else if (burst_act && !do_bst) begin
            beat_vld = 1'b1;
            beat_wr  = burst_wr;
        end
    end

    assign idx = MEM_AW'({beat_ba, beat_row, beat_col});

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_bl        <= 4'd1;
            mode_cl        <= 2'd2;
            mode_valid     <= 1'b0;
            protocol_error <= 1'b0;
            err_code       <= 3'd0;
            gtimer         <= 4'd0;
            burst_act      <= 1'b0;
            burst_wr       <= 1'b0;
            burst_ba       <= 2'd0;
            burst_row      <= '0;
            burst_col      <= '0;
            burst_len      <= 4'd1;
            burst_k        <= 4'd0;
            vld_pipe       <= 3'b000;
            rd_pipe        <= '0;
            dqm_d1         <= '0;
            dqm_d2         <= '0;
        end else begin
            if (err != ERR_NONE) begin
                protocol_error <= 1'b1;
                if (!protocol_error) err_code <= err;
            end
            if (do_lmr) begin
                mode_bl    <= bl_decode(sdram_addr[2:0]);
                mode_cl    <= cl_decode(sdram_addr[6:4]);
                mode_valid <= 1'b1;
                gtimer     <= 4'(tMRD_CYC - 1);
            end else if (do_ref) begin
                gtimer <= 4'(tRFC_CYC - 1);
            end else if (gtimer != 4'd0) begin
                gtimer <= gtimer - 4'd1;
            end
            if (do_rw) begin
                burst_wr  <= (cmd == CMD_WRITE);
                burst_ba  <= sdram_ba;
                burst_row <= bank_row[sdram_ba];
                burst_col <= sdram_addr[CAW-1:0];
                burst_len <= mode_bl;
            end
            if (beat_vld) begin
                burst_act <= !beat_last;
                burst_k   <= beat_k + 4'd1;
            end else if (do_bst) begin
                burst_act <= 1'b0;
            end
            // An abort drops every older read beat still in flight.
            if (do_rw || do_bst) vld_pipe <= {2'b00, beat_vld && !beat_wr};
            else                 vld_pipe <= {vld_pipe[1:0], beat_vld && !beat_wr};
            rd_pipe <= {rd_pipe[1:0], mem[idx]};
            dqm_d1  <= sdram_dqm;
            dqm_d2  <= dqm_d1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && beat_vld && beat_wr)
            for (int b = 0; b < NB; b++)
                if (!sdram_dqm[b]) mem[idx][b*8 +: 8] <= sdram_dq[b*8 +: 8];
    end

    assign tap = mode_cl - 2'd1;
    for (genvar b = 0; b < NB; b++) begin : g_dq
        assign sdram_dq[b*8 +: 8] = (vld_pipe[tap] && !dqm_d2[b]) ? rd_pipe[tap][b*8 +: 8] : 8'hzz;
    end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: drives pin-level commands on one
// edge per tick and checks outputs 1 time unit after each edge.
module tb_sdram_device_model;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101,
                           C_WR  = 4'b0100, C_LMR = 4'b0000;

    logic        clk, rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [11:0] addr;
    logic [1:0]  ba, dqm;
    logic [15:0] dq_o;
    logic        dq_en;
    wire  [15:0] dq;
    logic        mode_valid, protocol_error;
    logic [2:0]  err_code;
    int          n_chk, n_pass;
    logic [15:0] exp8 [8];

    assign dq = dq_en ? dq_o : 16'hzzzz;

    sdram_device_model dut (
        .clk(clk), .rst(rst), .sdram_cke(cke),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_addr(addr), .sdram_ba(ba), .sdram_dqm(dqm), .sdram_dq(dq),
        .mode_valid(mode_valid), .protocol_error(protocol_error), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // A released byte reads as all-z, or as zero where the simulator folds an
    // undriven net to 0; test data never contains a zero byte.
    function automatic logic [1:0] rel();
        logic [1:0] r;
        for (int b = 0; b < 2; b++)
            r[b] = (dq[b*8 +: 8] === 8'hzz) || (dq[b*8 +: 8] === 8'h00);
        return r;
    endfunction

    task automatic tick(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                        input logic den, input logic [15:0] d, input logic [1:0] m);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b; addr = a; dq_en = den; dq_o = d; dqm = m;
        @(posedge clk); #1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        dq_en = 1'b0; dqm = 2'b00;
    endtask

    task automatic nop(input int n);
        repeat (n) tick(C_NOP, 2'd0, 12'h000, 1'b0, 16'h0000, 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        cke = 1'b1; rst = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        addr = '0; ba = '0; dqm = '0; dq_o = '0; dq_en = 1'b0;
        exp8 = '{16'hB6B6, 16'hB7B7, 16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3, 16'hB4B4, 16'hB5B5};

        // reset state
        do_reset();
        chk("rst_mode_valid", mode_valid, 0);
        chk("rst_perr", protocol_error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_dq_hiz", rel(), 2'b11);

        // BL=4 CL=2 write then read back
        tick(C_LMR, 2'd0, 12'h022, 1'b0, 16'h0, 2'b00);
        chk("lmr_mode_valid", mode_valid, 1);
        nop(1);
        tick(C_ACT, 2'd1, 12'h005, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_WR, 2'd1, 12'h010, 1'b1, 16'hA0A0, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hA1A1, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hA2A2, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hA3A3, 2'b00);
        tick(C_RD, 2'd1, 12'h010, 1'b0, 16'h0, 2'b00);
        nop(1); chk("bl4_beat0", dq, 16'hA0A0);
        nop(1); chk("bl4_beat1", dq, 16'hA1A1);
        nop(1); chk("bl4_beat2", dq, 16'hA2A2);
        nop(1); chk("bl4_beat3", dq, 16'hA3A3);
        nop(1); chk("bl4_release", rel(), 2'b11);
        chk("bl4_no_err", protocol_error, 0);

        // BL=8 CL=3, wrapped read from col 6 with read DQM on beat 0 low byte
        tick(C_LMR, 2'd0, 12'h033, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_WR, 2'd1, 12'h000, 1'b1, 16'hB0B0, 2'b00);
        for (int k = 1; k < 8; k++)
            tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hB0B0 + 16'(k) * 16'h0101, 2'b00);
        tick(C_RD, 2'd1, 12'h006, 1'b0, 16'h0, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b0, 16'h0, 2'b01);
        chk("cl3_not_yet", rel(), 2'b11);
        nop(1);
        chk("cl3_beat0_lo_hiz", rel(), 2'b01);
        chk("cl3_beat0_hi", dq[15:8], 8'hB6);
        for (int k = 1; k < 8; k++) begin
            nop(1);
            chk($sformatf("cl3_beat%0d", k), dq, exp8[k]);
        end
        nop(1); chk("cl3_release", rel(), 2'b11);

        // READ to an idle bank
        tick(C_RD, 2'd2, 12'h000, 1'b0, 16'h0, 2'b00);
        chk("idle_perr", protocol_error, 1);
        chk("idle_code", err_code, 1);
        nop(2); chk("idle_dq_hiz_a", rel(), 2'b11);
        nop(1); chk("idle_dq_hiz_b", rel(), 2'b11);

        // tRCD violation, then ACT to open bank keeps first code
        do_reset();
        tick(C_LMR, 2'd0, 12'h022, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_ACT, 2'd0, 12'h003, 1'b0, 16'h0, 2'b00);
        tick(C_RD, 2'd0, 12'h000, 1'b0, 16'h0, 2'b00);
        chk("trcd_perr", protocol_error, 1);
        chk("trcd_code", err_code, 4);
        tick(C_ACT, 2'd0, 12'h003, 1'b0, 16'h0, 2'b00);
        chk("act_open_keeps_code", err_code, 4);

        // auto-precharge write, ACT after tRP is legal
        do_reset();
        tick(C_LMR, 2'd0, 12'h021, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_ACT, 2'd3, 12'h007, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_WR, 2'd3, 12'h420, 1'b1, 16'hC1C1, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hC2C2, 2'b00);
        nop(1);
        tick(C_ACT, 2'd3, 12'h007, 1'b0, 16'h0, 2'b00);
        chk("trp_met_no_err", protocol_error, 0);
        nop(1);
        tick(C_RD, 2'd3, 12'h020, 1'b0, 16'h0, 2'b00);
        nop(1); chk("ap_rd_beat0", dq, 16'hC1C1);
        nop(1); chk("ap_rd_beat1", dq, 16'hC2C2);
        nop(1); chk("ap_rd_release", rel(), 2'b11);

        // auto-precharge write, ACT one cycle after last beat violates tRP
        do_reset();
        tick(C_LMR, 2'd0, 12'h021, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_ACT, 2'd3, 12'h007, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_WR, 2'd3, 12'h420, 1'b1, 16'hD1D1, 2'b00);
        tick(C_NOP, 2'd0, 12'h000, 1'b1, 16'hD2D2, 2'b00);
        tick(C_ACT, 2'd3, 12'h007, 1'b0, 16'h0, 2'b00);
        chk("trp_perr", protocol_error, 1);
        chk("trp_code", err_code, 5);

        // reset mid read burst; array survives
        tick(C_LMR, 2'd0, 12'h022, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_ACT, 2'd1, 12'h005, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_RD, 2'd1, 12'h010, 1'b0, 16'h0, 2'b00);
        nop(1); chk("pre_rst_beat0", dq, 16'hA0A0);
        rst = 1'b1;
        nop(1);
        rst = 1'b0;
        chk("midrst_dq_hiz", rel(), 2'b11);
        chk("midrst_mode_valid", mode_valid, 0);
        chk("midrst_perr", protocol_error, 0);
        chk("midrst_code", err_code, 0);
        tick(C_LMR, 2'd0, 12'h022, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_ACT, 2'd1, 12'h005, 1'b0, 16'h0, 2'b00);
        nop(1);
        tick(C_RD, 2'd1, 12'h010, 1'b0, 16'h0, 2'b00);
        nop(1); chk("kept_beat0", dq, 16'hA0A0);
        nop(1); chk("kept_beat1", dq, 16'hA1A1);
        nop(1); chk("kept_beat2", dq, 16'hA2A2);
        nop(1); chk("kept_beat3", dq, 16'hA3A3);
        chk("kept_no_err", protocol_error, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
